// File: rtl/dmem_mmio_responder.sv
// Data-memory and MMIO responder for the core's M-stage data port: zero-latency loads,
// edge-registered stores, 64-bit cycle counter, GPIO register and a console byte FIFO.
module dmem_mmio_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        acc_err,
  output logic [31:0] gpio_out,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [32:0]   RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  localparam logic [2:0] OFF_CYC_LO  = 3'd0;
  localparam logic [2:0] OFF_CYC_HI  = 3'd1;
  localparam logic [2:0] OFF_GPIO    = 3'd2;
  localparam logic [2:0] OFF_CONSOLE = 3'd3;
  localparam logic [2:0] OFF_STATUS  = 3'd4;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   res = f3[2] ? {24'd0, b} : 32'(b);
      2'b01:   res = f3[2] ? {16'd0, h} : 32'(h);
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] lane, input logic [1:0] sz);
    logic [3:0] res;
    case (sz)
      2'b00:   res = 4'b0001 << lane;
      2'b01:   res = lane[1] ? 4'b1100 : 4'b0011;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  logic [1:0]    size;
  logic          is_mmio, is_ram, mapped, f3_ok, misalign, rd_ok, wr_ok;
  logic [2:0]    mmio_off;
  logic [AW-1:0] widx;

  assign size     = funct3[1:0];
  assign is_mmio  = (addr[31:5] == MMIO_BASE[31:5]);
  assign is_ram   = !is_mmio && ({1'b0, addr} < RAM_BYTES);
  assign mapped   = is_mmio | is_ram;
  assign mmio_off = addr[4:2];
  assign widx     = addr[AW+1:2];

  always_comb begin
    f3_ok = 1'b1;
    if (wen && !(funct3 inside {3'b000, 3'b001, 3'b010}))
      f3_ok = 1'b0;
    if (ren && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
      f3_ok = 1'b0;
  end

  assign misalign = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
  // Unmapped addresses never flag an error, whatever funct3 says.
  assign acc_err  = (wen | ren) && mapped && (!f3_ok || misalign || (is_mmio && size != 2'b10));
  assign rd_ok    = ren && mapped && !acc_err;
  assign wr_ok    = wen && mapped && !acc_err;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_word, st_data;
  logic [3:0]  st_be;
  logic        ram_we;

  assign mem_word = mem[widx];
  assign st_be    = store_be(addr[1:0], size);
  assign st_data  = (size == 2'b00) ? {4{wdata[7:0]}} :
                    (size == 2'b01) ? {2{wdata[15:0]}} : wdata;
  assign ram_we   = wr_ok && is_ram && !rst;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b]) mem[widx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  logic [63:0]   cyc_cnt;
  logic [31:0]   cyc_hi;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          ovf_sticky, err_sticky;
  logic          fifo_full, fifo_empty, pop, push_req, push_ok, ovf_set, clr_ovf, clr_err;
  logic [31:0]   status, mmio_rdata;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign con_valid  = !fifo_empty;
  assign con_data   = fifo_empty ? 8'd0 : fifo_mem[rd_ptr];
  assign pop        = con_valid && con_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_req   = wr_ok && is_mmio && (mmio_off == OFF_CONSOLE);
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_set    = push_req && !push_ok;
  assign clr_ovf    = wr_ok && is_mmio && (mmio_off == OFF_STATUS) && wdata[2];
  assign clr_err    = wr_ok && is_mmio && (mmio_off == OFF_STATUS) && wdata[3];
  assign status     = {24'd0, 4'(fifo_cnt), err_sticky, ovf_sticky, fifo_empty, fifo_full};

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt    <= '0;
      cyc_hi     <= '0;
      gpio_out   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      ovf_sticky <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 64'd1;
      if (rd_ok && is_mmio && (mmio_off == OFF_CYC_LO))
        cyc_hi <= cyc_cnt[63:32];
      if (wr_ok && is_mmio && (mmio_off == OFF_GPIO))
        gpio_out <= wdata;
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (push_ok && !pop)
        fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push_ok)
        fifo_cnt <= fifo_cnt - CW'(1);
      // Set beats clear when both land on the same edge.
      ovf_sticky <= ovf_set | (ovf_sticky & ~clr_ovf);
      err_sticky <= acc_err | (err_sticky & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_comb begin
    case (mmio_off)
      OFF_CYC_LO:  mmio_rdata = cyc_cnt[31:0];
      OFF_CYC_HI:  mmio_rdata = cyc_hi;
      OFF_GPIO:    mmio_rdata = gpio_out;
      OFF_CONSOLE: mmio_rdata = 32'd0;
      OFF_STATUS:  mmio_rdata = status;
      default:     mmio_rdata = 32'd0;
    endcase
    rdata = 32'd0;
    if (rd_ok)
      rdata = is_mmio ? mmio_rdata : load_extract(mem_word, addr[1:0], funct3);
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed scenarios plus randomized traffic checked
// against a byte-array / queue reference model.
module tb_dmem_mmio_responder;
  localparam int          DW = 1024;
  localparam int          FD = 4;
  localparam logic [31:0] MB = 32'h8000_0000;
  localparam logic [2:0]  F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_BU = 3'd4, F_HU = 3'd5;

  logic        clk = 1'b0;
  logic        rst, wen, ren, con_ready, acc_err, con_valid;
  logic [31:0] addr, wdata, rdata, gpio_out;
  logic [2:0]  funct3;
  logic [7:0]  con_data;

  dmem_mmio_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD), .MMIO_BASE(MB)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wen(wen), .ren(ren),
    .funct3(funct3), .rdata(rdata), .acc_err(acc_err), .gpio_out(gpio_out),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  m_mem [0:4095];
  logic [63:0] m_cnt;
  logic [31:0] m_hi, m_gpio;
  logic        m_ovf, m_err;
  logic [7:0]  m_fifo [$];
  logic [31:0] obs_rd;
  logic        obs_err;
  logic        cur_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_hi = 0; m_gpio = 0; m_ovf = 0; m_err = 0;
    m_fifo.delete();
  endtask

  function automatic logic [31:0] model_status();
    int n;
    n = m_fifo.size();
    return (n == FD ? 1 : 0) + (n == 0 ? 2 : 0) + (m_ovf ? 4 : 0) + (m_err ? 8 : 0) + n * 16;
  endfunction

  // Returns {acc_err, rdata} as the block should present them for this access.
  function automatic logic [32:0] model_out(input logic w, r, input logic [2:0] f3,
                                            input logic [31:0] a);
    bit ram, mmio, legal, mis, err;
    int nb;
    longint v;
    logic [31:0] rd;
    ram   = a < DW * 4;
    mmio  = (a >> 5) == (MB >> 5);
    nb    = 1 << f3[1:0];
    legal = w ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    mis   = (a % nb) != 0;
    err   = (w || r) && (ram || mmio) && (!legal || mis || (mmio && nb != 4));
    rd    = 0;
    if (r && !err) begin
      if (ram) begin
        v = 0;
        for (int i = 0; i < nb; i++) v += longint'(m_mem[a + i]) << (8 * i);
        if (f3[2] == 1'b0 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
          v -= (longint'(1) << (8 * nb));
        rd = v[31:0];
      end else if (mmio) begin
        case (a - MB)
          32'd0:   rd = m_cnt[31:0];
          32'd4:   rd = m_hi;
          32'd8:   rd = m_gpio;
          32'd16:  rd = model_status();
          default: rd = 0;
        endcase
      end
    end
    return {err, rd};
  endfunction

  task automatic model_next(input logic w, r, input logic [2:0] f3, input logic [31:0] a, d,
                            input logic rdy, rs, err);
    logic [63:0] old;
    bit mmio, ram, pop, push, ovf_set;
    int nb, sz;
    logic [31:0] off;
    if (rs) begin
      model_reset();
      return;
    end
    old  = m_cnt;
    m_cnt = m_cnt + 1;
    mmio = (a >> 5) == (MB >> 5);
    ram  = a < DW * 4;
    off  = a - MB;
    nb   = 1 << f3[1:0];
    if (r && !err && mmio && off == 0) m_hi = old[63:32];
    if (w && !err && mmio && off == 8) m_gpio = d;
    if (w && !err && ram)
      for (int i = 0; i < nb; i++) m_mem[a + i] = d[8*i +: 8];
    sz      = m_fifo.size();
    pop     = (sz != 0) && rdy;
    push    = w && !err && mmio && off == 12;
    ovf_set = 0;
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (sz < FD || pop) m_fifo.push_back(d[7:0]);
      else ovf_set = 1;
    end
    if (w && !err && mmio && off == 16 && d[2]) m_ovf = 0;
    if (ovf_set) m_ovf = 1;
    if (w && !err && mmio && off == 16 && d[3]) m_err = 0;
    if (err) m_err = 1;
  endtask

  // One clock: drive at the falling edge, check outputs, advance model across the rising edge.
  task automatic step(input logic w, r, input logic [2:0] f3, input logic [31:0] a, d,
                      input logic rdy, rs);
    logic [32:0] e;
    wen = w; ren = r; funct3 = f3; addr = a; wdata = d; con_ready = rdy; rst = rs;
    #1;
    e = model_out(w, r, f3, a);
    obs_rd  = rdata;
    obs_err = acc_err;
    check("rdata", rdata, e[31:0]);
    check("acc_err", acc_err, e[32]);
    check("con_valid", con_valid, m_fifo.size() != 0);
    check("con_data", con_data, (m_fifo.size() != 0) ? m_fifo[0] : 8'd0);
    check("gpio_out", gpio_out, m_gpio);
    model_next(w, r, f3, a, d, rdy, rs, e[32]);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, d);
    step(1'b1, 1'b0, f3, a, d, cur_rdy, 1'b0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a);
    step(1'b0, 1'b1, f3, a, 32'd0, cur_rdy, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, F_W, 32'd0, 32'd0, cur_rdy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) m_mem[i] = 8'd0;
    cur_rdy = 0; wen = 0; ren = 0; funct3 = 0; addr = 0; wdata = 0; con_ready = 0; rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 0;
    #1;
    check("rst_gpio", gpio_out, 0);
    check("rst_con_valid", con_valid, 0);
    check("rst_con_data", con_data, 0);

    repeat (10) idle();
    ld(F_W, MB);      check("cyc_lo_10", obs_rd, 10);
    ld(F_W, MB + 4);  check("cyc_hi_shadow", obs_rd, 0);

    for (int i = 0; i < 16; i++) st(F_W, 4 * i, 32'd0);
    st(F_W, 32'h10, 32'h8001_7F80);
    ld(F_B, 32'h10);  check("lb", obs_rd, 32'hFFFF_FF80);
    ld(F_BU, 32'h11); check("lbu", obs_rd, 32'h0000_007F);
    ld(F_H, 32'h12);  check("lh", obs_rd, 32'hFFFF_8001);
    ld(F_HU, 32'h12); check("lhu", obs_rd, 32'h0000_8001);
    st(F_B, 32'h13, 32'h0000_00AA);
    ld(F_W, 32'h10);  check("lw_after_sb", obs_rd, 32'hAA01_7F80);

    st(F_W, 32'h06, 32'hDEAD_BEEF); check("mis_err", obs_err, 1);
    ld(F_W, 32'h04);  check("mis_unchanged", obs_rd, 0);
    ld(F_W, MB + 16); check("err_sticky_set", obs_rd[3], 1);
    st(F_W, MB + 16, 32'h8);
    ld(F_W, MB + 16); check("err_sticky_clr", obs_rd[3], 0);
    ld(3'b011, 32'h10);
    check("ill_rdata", obs_rd, 0);
    check("ill_err", obs_err, 1);

    st(F_W, MB + 8, 32'h1234_5678); check("gpio_write", gpio_out, 32'h1234_5678);

    cur_rdy = 0;
    for (int i = 0; i < 5; i++) st(F_W, MB + 12, 32'h41 + i);
    ld(F_W, MB + 16);
    check("fifo_full", obs_rd[0], 1);
    check("fifo_count", obs_rd[7:4], 4);
    check("fifo_ovf", obs_rd[2], 1);
    st(F_W, MB + 16, 32'hC);
    cur_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", con_valid, 1);
      check("drain_byte", con_data, 8'h41 + i);
      idle();
    end
    check("drain_empty", con_valid, 0);

    cur_rdy = 0;
    for (int i = 0; i < 4; i++) st(F_W, MB + 12, 32'h61 + i);
    step(1'b1, 1'b0, F_W, MB + 12, 32'h7A, 1'b1, 1'b0);
    ld(F_W, MB + 16);
    check("fullpop_count", obs_rd[7:4], 4);
    check("fullpop_ovf", obs_rd[2], 0);
    check("fullpop_head", con_data, 8'h62);

    step(1'b1, 1'b0, F_W, MB + 8, 32'hDEAD_0001, 1'b0, 1'b1);
    step(1'b1, 1'b0, F_W, 32'h20, 32'h5555_AAAA, 1'b0, 1'b1);
    check("rst_gpio_mid", gpio_out, 0);
    check("rst_fifo_mid", con_valid, 0);
    ld(F_W, MB);      check("rst_counter_mid", obs_rd, 0);
    ld(F_W, 32'h20);  check("rst_store_dropped", obs_rd, 0);

    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      logic        w, r;
      int          k, op;
      k = $urandom_range(0, 9);
      if (k < 5)
        a = $urandom_range(0, 63);
      else if (k < 8)
        a = ($urandom_range(0, 3) == 0) ? MB + $urandom_range(0, 31) : MB + 4 * $urandom_range(0, 7);
      else begin
        case ($urandom_range(0, 2))
          0:       a = 32'h0000_1000 + $urandom_range(0, 255);
          1:       a = MB + 32 + $urandom_range(0, 63);
          default: a = 32'h4000_0000;
        endcase
      end
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (k >= 5)               f3 = F_W;
      else begin
        case ($urandom_range(0, 4))
          0:       f3 = F_B;
          1:       f3 = F_H;
          2:       f3 = F_W;
          3:       f3 = F_BU;
          default: f3 = F_HU;
        endcase
      end
      op = $urandom_range(0, 3);
      w  = (op == 1);
      r  = (op >= 2);
      step(w, r, f3, a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
